// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory-sequencer states, default bus widths and
// the wait-counter width helper.
package lc3_pkg;
    localparam int LC3_ADDR_W = 16;
    localparam int LC3_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } seq_state_e;

    // clog2(timeout+1), never narrower than one bit
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction
endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// Request/ready bus between the LC-3 memory sequencer and external memory.
interface lc3_mem_sequencer_if
    import lc3_pkg::*;
#(
    parameter int ADDR_W = LC3_ADDR_W,
    parameter int DATA_W = LC3_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lc3_wait_timer.sv
// Saturating wait counter; o_hit flags the last permitted REQ cycle.
module lc3_wait_timer
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
    end

    // TIMEOUT of zero means wait forever
    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_hit = 1'b0;
        end else begin : g_on
            assign o_hit = (r_cnt == CW'(TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/lc3_mem_sequencer.sv
// LC-3 MAR/MDR owner: turns datapath load/memory strobes into a req/ready
// transaction and stalls the control FSM until memory completes or times out.
module lc3_mem_sequencer
    import lc3_pkg::*;
#(
    parameter int                ADDR_W   = LC3_ADDR_W,
    parameter int                DATA_W   = LC3_DATA_W,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ldMAR,
    input  logic                 ldMDR,
    input  logic                 selMDR,
    input  logic                 memWE,
    input  logic [DATA_W-1:0]    bus_in,
    input  logic                 err_clr,
    output logic [ADDR_W-1:0]    mar_out,
    output logic [DATA_W-1:0]    mdr_out,
    output logic                 stall,
    output logic                 err_sticky,
    lc3_mem_sequencer_if.master  mem
);
    seq_state_e        r_state;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_req;
    logic              r_we;
    logic              r_err;

    logic w_wr;
    logic w_start;
    logic w_hit;

    // a write beats a simultaneous read
    assign w_wr    = memWE;
    assign w_start = (ldMDR & selMDR) | memWE;

    assign stall = (r_state == ST_REQ) || (r_state == ST_IDLE && w_start);

    lc3_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (r_state != ST_REQ),
        .i_en  (r_state == ST_REQ),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (err_clr)
                r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ldMAR)
                        r_mar <= bus_in[ADDR_W-1:0];
                    if (ldMDR && !selMDR)
                        r_mdr <= bus_in;
                    if (w_start) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_we    <= w_wr;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ready) begin
                        if (!r_we)
                            r_mdr <= mem.mem_rdata;
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                    end else if (w_hit) begin
                        if (!r_we)
                            r_mdr <= ERR_DATA;
                        r_state <= ST_ERR;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mar_out       = r_mar;
    assign mdr_out       = r_mdr;
    assign err_sticky    = r_err;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_mar;
    assign mem.mem_wdata = r_mdr;
endmodule
